// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with a latency-matched, blanked pixel output stage.
// Request side publishes (x, y); the output side realigns sync/active with the returned colour.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int COLOR_W   = 4,
    parameter int XW        = 10,
    parameter int YW        = 10,
    parameter int CLK_DIV   = 1,
    parameter int PIX_LAT   = 1
) (
    input  logic               dclk,
    input  logic               clr,
    output logic               pix_en,
    output logic [XW-1:0]      x,
    output logic [YW-1:0]      y,
    output logic               req_active,
    input  logic [COLOR_W-1:0] red,
    input  logic [COLOR_W-1:0] green,
    input  logic [COLOR_W-1:0] blue,
    output logic               hsync,
    output logic               vsync,
    output logic [COLOR_W-1:0] red_o,
    output logic [COLOR_W-1:0] green_o,
    output logic [COLOR_W-1:0] blue_o,
    output logic               active_o,
    output logic               line_start,
    output logic               frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
    localparam logic [XW-1:0] X_VIS    = XW'(H_ACTIVE);
    localparam logic [YW-1:0] Y_VIS    = YW'(V_ACTIVE);
    localparam logic [XW-1:0] HS_BEG   = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] VS_BEG   = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          HS_ON    = 1'(HSYNC_POL);
    localparam logic          VS_ON    = 1'(VSYNC_POL);

    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
    } sync_t;

    logic [DW-1:0] div;
    logic          x_wrap;
    logic          y_wrap;
    sync_t         cur;
    sync_t         last;
    sync_t         pipe [PIX_LAT];

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            div <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Gated by clr so no strobe is seen while reset is held.
    assign pix_en = ~clr & (div == DIV_LAST);

    assign x_wrap = (x == X_LAST);
    assign y_wrap = (y == Y_LAST);

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            x <= '0;
            y <= '0;
        end else if (pix_en) begin
            if (x_wrap) begin
                x <= '0;
                y <= y_wrap ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= pix_en & x_wrap;
            frame_start <= pix_en & x_wrap & y_wrap;
        end
    end

    assign req_active = (x < X_VIS) && (y < Y_VIS);

    always_comb begin
        cur     = '0;
        cur.hs  = (x >= HS_BEG) && (x < HS_END);
        cur.vs  = (y >= VS_BEG) && (y < VS_END);
        cur.act = req_active;
    end

    // Delay sync/active by the pixel source latency so they meet the colour.
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < PIX_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else if (pix_en) begin
            pipe[0] <= cur;
            for (int i = 1; i < PIX_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign last = pipe[PIX_LAT-1];

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            hsync    <= ~HS_ON;
            vsync    <= ~VS_ON;
            active_o <= 1'b0;
            red_o    <= '0;
            green_o  <= '0;
            blue_o   <= '0;
        end else if (pix_en) begin
            hsync    <= last.hs ? HS_ON : ~HS_ON;
            vsync    <= last.vs ? VS_ON : ~VS_ON;
            active_o <= last.act;
            red_o    <= last.act ? red : '0;
            green_o  <= last.act ? green : '0;
            blue_o   <= last.act ? blue : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: small-geometry timing, latency alignment,
// clock divider with inverted hsync polarity, and mid-frame reset.
module tb_vga_timing_gen;

    logic dclk = 1'b0;
    always #5 dclk = ~dclk;

    logic clr_a = 1'b1;
    logic clr_b = 1'b1;
    logic clr_c = 1'b1;

    int checks = 0;
    int errors = 0;

    // Instance A: H 8/2/3/2, V 4/1/2/1, PIX_LAT 1, CLK_DIV 1
    logic       pix_en_a, req_a, hsync_a, vsync_a, act_a, ls_a, fs_a;
    logic [9:0] x_a, y_a;
    logic [3:0] red_a = 4'h5;
    logic [3:0] green_a = 4'ha;
    logic [3:0] blue_a = 4'h3;
    logic [3:0] ro_a, go_a, bo_a;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_a (
        .dclk(dclk), .clr(clr_a), .pix_en(pix_en_a),
        .x(x_a), .y(y_a), .req_active(req_a),
        .red(red_a), .green(green_a), .blue(blue_a),
        .hsync(hsync_a), .vsync(vsync_a),
        .red_o(ro_a), .green_o(go_a), .blue_o(bo_a),
        .active_o(act_a), .line_start(ls_a), .frame_start(fs_a)
    );

    // Instance B: same geometry, PIX_LAT 2, red = x[3:0] delayed 2 strobes
    logic       pix_en_b, req_b, hsync_b, vsync_b, act_b, ls_b, fs_b;
    logic [9:0] x_b, y_b;
    logic [3:0] red_b;
    logic [3:0] green_b = 4'h0;
    logic [3:0] blue_b = 4'h0;
    logic [3:0] ro_b, go_b, bo_b;
    logic [3:0] d1, d2;

    always @(posedge dclk or posedge clr_b) begin
        if (clr_b) begin
            d1 <= 4'h0;
            d2 <= 4'h0;
        end else if (pix_en_b) begin
            d1 <= x_b[3:0];
            d2 <= d1;
        end
    end
    assign red_b = d2;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .PIX_LAT(2)
    ) u_b (
        .dclk(dclk), .clr(clr_b), .pix_en(pix_en_b),
        .x(x_b), .y(y_b), .req_active(req_b),
        .red(red_b), .green(green_b), .blue(blue_b),
        .hsync(hsync_b), .vsync(vsync_b),
        .red_o(ro_b), .green_o(go_b), .blue_o(bo_b),
        .active_o(act_b), .line_start(ls_b), .frame_start(fs_b)
    );

    // Instance C: 640x480 defaults, CLK_DIV 2, HSYNC_POL 1
    logic       pix_en_c, req_c, hsync_c, vsync_c, act_c, ls_c, fs_c;
    logic [9:0] x_c, y_c;
    logic [3:0] red_c = 4'h0;
    logic [3:0] green_c = 4'h0;
    logic [3:0] blue_c = 4'h0;
    logic [3:0] ro_c, go_c, bo_c;

    vga_timing_gen #(
        .CLK_DIV(2), .HSYNC_POL(1)
    ) u_c (
        .dclk(dclk), .clr(clr_c), .pix_en(pix_en_c),
        .x(x_c), .y(y_c), .req_active(req_c),
        .red(red_c), .green(green_c), .blue(blue_c),
        .hsync(hsync_c), .vsync(vsync_c),
        .red_o(ro_c), .green_o(go_c), .blue_o(bo_c),
        .active_o(act_c), .line_start(ls_c), .frame_start(fs_c)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // k = dclk edges since reset release; outputs trail the request by 2 edges.
    task automatic check_a(input int k);
        int  p;
        int  px;
        int  py;
        logic hs;
        logic vs;
        logic act;
        p   = k - 2;
        px  = (p >= 0) ? p % 15 : 0;
        py  = (p >= 0) ? (p / 15) % 8 : 0;
        hs  = !(p >= 0 && px >= 10 && px <= 12);
        vs  = !(p >= 0 && py >= 5 && py <= 6);
        act = (p >= 0) && (px < 8) && (py < 4);
        chk($sformatf("a_pix@%0d", k), pix_en_a, 1);
        chk($sformatf("a_x@%0d", k), x_a, k % 15);
        chk($sformatf("a_y@%0d", k), y_a, (k / 15) % 8);
        chk($sformatf("a_req@%0d", k), req_a,
            (k % 15 < 8) && ((k / 15) % 8 < 4));
        chk($sformatf("a_hs@%0d", k), hsync_a, hs);
        chk($sformatf("a_vs@%0d", k), vsync_a, vs);
        chk($sformatf("a_act@%0d", k), act_a, act);
        chk($sformatf("a_red@%0d", k), ro_a, act ? 5 : 0);
        chk($sformatf("a_grn@%0d", k), go_a, act ? 10 : 0);
        chk($sformatf("a_ls@%0d", k), ls_a, k % 15 == 0);
        chk($sformatf("a_fs@%0d", k), fs_a, k % 120 == 0);
    endtask

    task automatic check_b(input int k);
        int  p;
        int  px;
        int  py;
        logic hs;
        logic act;
        p   = k - 3;
        px  = (p >= 0) ? p % 15 : 0;
        py  = (p >= 0) ? (p / 15) % 8 : 0;
        hs  = !(p >= 0 && px >= 10 && px <= 12);
        act = (p >= 0) && (px < 8) && (py < 4);
        chk($sformatf("b_hs@%0d", k), hsync_b, hs);
        chk($sformatf("b_act@%0d", k), act_b, act);
        chk($sformatf("b_red@%0d", k), ro_b, act ? px : 0);
    endtask

    // Strobes land on even edges; output position = k/2 - 2.
    task automatic check_c(input int k);
        int  p;
        logic hs;
        p  = k / 2 - 2;
        hs = (k >= 4) && (p % 800 >= 656) && (p % 800 < 752);
        chk($sformatf("c_pix@%0d", k), pix_en_c, k % 2);
        chk($sformatf("c_x@%0d", k), x_c, (k / 2) % 800);
        chk($sformatf("c_hs@%0d", k), hsync_c, hs);
        chk($sformatf("c_vs@%0d", k), vsync_c, 1);
        chk($sformatf("c_ls@%0d", k), ls_c, k % 1600 == 0);
    endtask

    initial begin
        int ls_cnt;
        int fs_cnt;
        int hs_c_cnt;
        int first_ls;
        int second_ls;
        logic found;
        ls_cnt    = 0;
        fs_cnt    = 0;
        hs_c_cnt  = 0;
        first_ls  = -1;
        second_ls = -1;
        found     = 1'b0;

        repeat (3) @(negedge dclk);
        chk("rst_a_x", x_a, 0);
        chk("rst_a_y", y_a, 0);
        chk("rst_a_hs", hsync_a, 1);
        chk("rst_a_vs", vsync_a, 1);
        chk("rst_a_red", ro_a, 0);
        chk("rst_a_blu", bo_a, 0);
        chk("rst_a_act", act_a, 0);
        chk("rst_a_fs", fs_a, 0);
        chk("rst_a_ls", ls_a, 0);
        chk("rst_a_pix", pix_en_a, 0);
        chk("rst_a_req", req_a, 1);
        chk("rst_c_hs", hsync_c, 0);
        chk("rst_c_pix", pix_en_c, 0);

        clr_a = 1'b0;
        clr_b = 1'b0;
        clr_c = 1'b0;
        for (int k = 1; k <= 3400; k++) begin
            @(negedge dclk);
            if (k <= 250) begin
                check_a(k);
                check_b(k);
                ls_cnt += int'(ls_a);
                fs_cnt += int'(fs_a);
            end
            check_c(k);
            hs_c_cnt += int'(hsync_c);
            if (ls_c) begin
                if (first_ls < 0) first_ls = k;
                else if (second_ls < 0) second_ls = k;
            end
        end
        chk("a_ls_count", ls_cnt, 16);
        chk("a_fs_count", fs_cnt, 2);
        chk("c_hs_count", hs_c_cnt, 384);
        chk("c_line_period", second_ls - first_ls, 1600);

        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge dclk);
            if (x_a == 10'd9 && y_a == 10'd2) found = 1'b1;
        end
        chk("a_find_pos", found, 1);
        chk("mid_red_before", ro_a, 5);

        clr_a = 1'b1;
        #1;
        chk("mid_x", x_a, 0);
        chk("mid_y", y_a, 0);
        chk("mid_hs", hsync_a, 1);
        chk("mid_vs", vsync_a, 1);
        chk("mid_red", ro_a, 0);
        chk("mid_act", act_a, 0);
        chk("mid_pix", pix_en_a, 0);
        chk("mid_ls", ls_a, 0);
        chk("mid_fs", fs_a, 0);
        chk("mid_req", req_a, 1);

        @(negedge dclk);
        clr_a = 1'b0;
        for (int k = 1; k <= 130; k++) begin
            @(negedge dclk);
            check_a(k);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
